fsm5_observer: RTL and testbench
================================

# fsm5_observer

Passive state observer for the team's 5-state Mealy-output lab FSM. It watches the `(sw_in, out)` pairs the FSM produces and keeps the set of FSM states consistent with the whole observation history. It reports when that set narrows to one state (lock) and when an observation fits no state (mismatch). It sits beside the FSM on the lab board, or on the bench, as a conformance checker and receives only what the FSM drives.

## Interface
- No parameters. The transition/output table below is fixed in RTL.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `obs_valid` input 1: one observation is present this cycle; accepted every cycle, no backpressure.
- `obs_sw` input 2: switch value applied for the observed step.
- `obs_out` input 1: FSM output bit produced by that step.
- `seed_valid` input 1: load the candidate set from `seed_mask`.
- `seed_mask` input 5: bit i = FSM state i is a candidate.
- `cand_mask` output 5: current candidate set, bit i = state i.
- `locked` output 1: `cand_mask` has exactly one bit set.
- `state_est` output 3: index of the single candidate when `locked`, else 3'd7.
- `mismatch` output 1: one-cycle pulse, the last observation emptied the set.
- `mismatch_cnt` output 8: saturating count of mismatches.

## Operation
- Golden table, written as state: sw0, sw1, sw2, sw3 → next/out:
  - S0: 1/0, 0/1, 3/0, 4/1
  - S1: 3/0, 0/1, 0/1, 4/1
  - S2: 2/1, 2/1, 3/0, 1/0
  - S3: 4/1, 2/1, 1/0, 4/1
  - S4: 2/1, 3/0, 0/1, 0/1
- Update on an accepted observation, for each state s with `cand_mask[s]=1` and `out(s,obs_sw)==obs_out`:
  - OR the one-hot of `next(s,obs_sw)` into `new_mask`.
  - `cand_mask <= new_mask`.
- Mismatch handling: if `new_mask==0`, then `cand_mask <= 5'b11111`, `mismatch` pulses for 1 cycle, and `mismatch_cnt` increments, holding at 255.
- Seed handling: `seed_valid` loads `seed_mask` into `cand_mask`.
  - A seed of 5'b00000 loads 5'b11111 instead. It does not pulse `mismatch` and does not count.
- Priority per cycle, highest first: `reset` > `seed_valid` > `obs_valid`.
  - If `seed_valid` and `obs_valid` are both high, the observation is dropped.
- No observation and no seed: all state holds; `mismatch` is 0.
- `locked` and `state_est` are registered and always consistent with the `cand_mask` value in the same cycle.
- Bits 5..7 of `state_est` encoding are never produced except 7, which means "not locked".

## Timing
- Reset values: `cand_mask`=5'b11111, `locked`=0, `state_est`=7, `mismatch`=0, `mismatch_cnt`=0.
- Latency: an input accepted at edge N is reflected on all outputs after edge N, i.e. 1 cycle.
- Throughput: one observation per cycle, back-to-back.
- Reset mid-sequence discards all history in one cycle. Reset outranks seed and observation in the same cycle.
- Counter saturation: at 255 a further mismatch still pulses `mismatch` and still reloads all-ones, but the count stays 255.

## Test plan
- Reset, then observations (0,0), (1,1), (2,0) on consecutive cycles → `cand_mask` 01010, then 00101, then 01000. `locked`=1 and `state_est`=3 after the third edge.
- From the locked S3 state, observe (2,1) → `mismatch` pulses 1 cycle, `cand_mask`=11111, `locked`=0, `state_est`=7, `mismatch_cnt`=1.
- After reset, observe (3,1) → `cand_mask`=10001, not locked. Then seed 00001 and observe (3,1) → `cand_mask`=10000, `state_est`=4.
- Seed 00100 with a simultaneous `obs_valid` (0,1) → `cand_mask`=00100 (observation dropped). Next cycle (0,1) → `cand_mask` stays 00100, `locked`, `state_est`=2.
- Drive 300 mismatching observations, e.g. seed 00100 then (2,1) repeatedly → `mismatch_cnt` stops at 255 and `mismatch` still pulses each time.
- Assert `reset` in the same cycle as `seed_valid` and `obs_valid` → all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/fsm5_observer_if.sv
// Observation/seed bus for fsm5_observer.
// Carries the observed (sw, out) step and the seed load toward the observer,
// and the observer's candidate-set status back to whoever watches it.
//   master: drives obs_valid/obs_sw/obs_out/seed_valid/seed_mask, reads status
//   slave : the observer itself
interface fsm5_observer_if;
  logic       obs_valid;
  logic [1:0] obs_sw;
  logic       obs_out;
  logic       seed_valid;
  logic [4:0] seed_mask;
  logic [4:0] cand_mask;
  logic       locked;
  logic [2:0] state_est;
  logic       mismatch;
  logic [7:0] mismatch_cnt;

  modport master (
    output obs_valid, obs_sw, obs_out, seed_valid, seed_mask,
    input  cand_mask, locked, state_est, mismatch, mismatch_cnt
  );

  modport slave (
    input  obs_valid, obs_sw, obs_out, seed_valid, seed_mask,
    output cand_mask, locked, state_est, mismatch, mismatch_cnt
  );
endinterface

// File: rtl/fsm5_observer.sv
// fsm5_observer: passive state observer for the 5-state Mealy lab FSM.
// Tracks the set of FSM states consistent with every (sw, out) pair seen so
// far, flags when that set is a single state, and pulses/counts when an
// observation fits no candidate (the set is then reopened to all states).
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - fsm5_observer_if.slave:
//            obs_valid/obs_sw/obs_out  observation input, one per cycle max
//            seed_valid/seed_mask      load candidate set (0 loads all-ones)
//            cand_mask                 current candidate set, bit i = state i
//            locked/state_est          single-candidate flag and its index (7 = none)
//            mismatch/mismatch_cnt     empty-set pulse and saturating count
module fsm5_observer (
  input logic              clk,
  input logic              reset,
  fsm5_observer_if.slave   bus
);

  typedef enum logic [2:0] {
    S0   = 3'd0,
    S1   = 3'd1,
    S2   = 3'd2,
    S3   = 3'd3,
    S4   = 3'd4,
    NONE = 3'd7
  } fsm_state_e;

  typedef struct packed {
    fsm_state_e nxt;
    logic       out;
  } step_t;

  // Golden transition/output table of the observed FSM.
  function automatic step_t golden(input fsm_state_e s, input logic [1:0] sw);
    step_t r;
    r = '{nxt: NONE, out: 1'b0};
    unique case (s)
      S0: case (sw)
            2'd0: r = '{S1, 1'b0};
            2'd1: r = '{S0, 1'b1};
            2'd2: r = '{S3, 1'b0};
            default: r = '{S4, 1'b1};
          endcase
      S1: case (sw)
            2'd0: r = '{S3, 1'b0};
            2'd1: r = '{S0, 1'b1};
            2'd2: r = '{S0, 1'b1};
            default: r = '{S4, 1'b1};
          endcase
      S2: case (sw)
            2'd0: r = '{S2, 1'b1};
            2'd1: r = '{S2, 1'b1};
            2'd2: r = '{S3, 1'b0};
            default: r = '{S1, 1'b0};
          endcase
      S3: case (sw)
            2'd0: r = '{S4, 1'b1};
            2'd1: r = '{S2, 1'b1};
            2'd2: r = '{S1, 1'b0};
            default: r = '{S4, 1'b1};
          endcase
      S4: case (sw)
            2'd0: r = '{S2, 1'b1};
            2'd1: r = '{S3, 1'b0};
            2'd2: r = '{S0, 1'b1};
            default: r = '{S0, 1'b1};
          endcase
      default: r = '{NONE, 1'b0};
    endcase
    return r;
  endfunction

  logic [4:0] cand_q, cand_d;
  logic       locked_q, locked_d;
  logic [2:0] est_q, est_d;
  logic       mm_q, mm_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] new_mask;
  step_t      st;

  // Image of the candidate set under the observed step, keeping only
  // states whose output agrees with the observed bit.
  always_comb begin
    new_mask = '0;
    st       = '{nxt: NONE, out: 1'b0};
    for (int unsigned s = 0; s < 5; s++) begin
      st = golden(fsm_state_e'(3'(s)), bus.obs_sw);
      if (cand_q[s] && (st.out == bus.obs_out))
        new_mask = new_mask | (5'b00001 << st.nxt);
    end
  end

  always_comb begin
    cand_d = cand_q;
    mm_d   = 1'b0;
    cnt_d  = cnt_q;
    if (bus.seed_valid) begin
      cand_d = (bus.seed_mask == '0) ? '1 : bus.seed_mask;
    end else if (bus.obs_valid) begin
      if (new_mask == '0) begin
        cand_d = '1;
        mm_d   = 1'b1;
        if (cnt_q != '1)
          cnt_d = cnt_q + 8'd1;
      end else begin
        cand_d = new_mask;
      end
    end

    // Lock status is computed from the next set so it is registered in
    // step with cand_mask rather than lagging it by a cycle.
    locked_d = (cand_d != '0) && ((cand_d & (cand_d - 5'd1)) == '0);
    est_d    = NONE;
    for (int unsigned s = 0; s < 5; s++) begin
      if (locked_d && cand_d[s])
        est_d = 3'(s);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand_q   <= '1;
      locked_q <= 1'b0;
      est_q    <= NONE;
      mm_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cand_q   <= cand_d;
      locked_q <= locked_d;
      est_q    <= est_d;
      mm_q     <= mm_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.cand_mask    = cand_q;
  assign bus.locked       = locked_q;
  assign bus.state_est    = est_q;
  assign bus.mismatch     = mm_q;
  assign bus.mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_fsm5_observer.sv
module tb_fsm5_observer;

  logic clk;
  logic reset;
  fsm5_observer_if bus ();

  fsm5_observer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  cand;
    logic        mm;
    logic [7:0]  cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Expected lock flag / index from a hand-given candidate set.
  function automatic logic exp_locked(input logic [4:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) if (m[i]) n++;
    return (n == 1);
  endfunction

  function automatic logic [2:0] exp_est(input logic [4:0] m);
    logic [2:0] e;
    e = 3'd7;
    if (exp_locked(m))
      for (int i = 0; i < 5; i++) if (m[i]) e = 3'(i);
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares the scoreboard head once its output cycle arrives.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e = sb.pop_front();
      chk({e.tag, ".cand_mask"}, int'(bus.cand_mask), int'(e.cand));
      chk({e.tag, ".locked"}, int'(bus.locked), int'(exp_locked(e.cand)));
      chk({e.tag, ".state_est"}, int'(bus.state_est), int'(exp_est(e.cand)));
      chk({e.tag, ".mismatch"}, int'(bus.mismatch), int'(e.mm));
      chk({e.tag, ".mismatch_cnt"}, int'(bus.mismatch_cnt), int'(e.cnt));
    end
  end

  // Drive one cycle of stimulus and queue the outputs expected after the edge.
  task automatic step(input string tag, input logic rst,
                      input logic sv, input logic [4:0] sm,
                      input logic ov, input logic [1:0] sw, input logic o,
                      input logic [4:0] ecand, input logic emm, input logic [7:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.seed_valid = sv;
    bus.seed_mask  = sm;
    bus.obs_valid  = ov;
    bus.obs_sw     = sw;
    bus.obs_out    = o;
    e.cyc  = cyc_cnt + 1;
    e.cand = ecand;
    e.mm   = emm;
    e.cnt  = ecnt;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic obs(input string tag, input logic [1:0] sw, input logic o,
                     input logic [4:0] ecand, input logic emm, input logic [7:0] ecnt);
    step(tag, 1'b0, 1'b0, 5'b0, 1'b1, sw, o, ecand, emm, ecnt);
  endtask

  task automatic seed(input string tag, input logic [4:0] sm,
                      input logic [4:0] ecand, input logic [7:0] ecnt);
    step(tag, 1'b0, 1'b1, sm, 1'b0, 2'd0, 1'b0, ecand, 1'b0, ecnt);
  endtask

  task automatic idle(input string tag, input logic [4:0] ecand, input logic [7:0] ecnt);
    step(tag, 1'b0, 1'b0, 5'b0, 1'b0, 2'd0, 1'b0, ecand, 1'b0, ecnt);
  endtask

  initial begin
    int unsigned budget;
    reset          = 1'b1;
    bus.seed_valid = 1'b0;
    bus.seed_mask  = '0;
    bus.obs_valid  = 1'b0;
    bus.obs_sw     = '0;
    bus.obs_out    = 1'b0;

    step("reset0", 1'b1, 1'b0, 5'b0, 1'b0, 2'd0, 1'b0, 5'b11111, 1'b0, 8'd0);

    // Narrowing to S3
    obs("t1_obs00", 2'd0, 1'b0, 5'b01010, 1'b0, 8'd0);
    obs("t1_obs11", 2'd1, 1'b1, 5'b00101, 1'b0, 8'd0);
    obs("t1_obs20", 2'd2, 1'b0, 5'b01000, 1'b0, 8'd0);
    // Mismatch from locked S3
    obs("t2_obs21", 2'd2, 1'b1, 5'b11111, 1'b1, 8'd1);
    idle("t2_idle", 5'b11111, 8'd1);
    // Partial narrowing, seeding, and history reset
    step("t3_reset", 1'b1, 1'b0, 5'b0, 1'b0, 2'd0, 1'b0, 5'b11111, 1'b0, 8'd0);
    obs("t3_obs31", 2'd3, 1'b1, 5'b10001, 1'b0, 8'd0);
    seed("t3_seed1", 5'b00001, 5'b00001, 8'd0);
    obs("t3_obs31b", 2'd3, 1'b1, 5'b10000, 1'b0, 8'd0);
    // Seed wins over simultaneous observation
    step("t4_seedobs", 1'b0, 1'b1, 5'b00100, 1'b1, 2'd0, 1'b1, 5'b00100, 1'b0, 8'd0);
    obs("t4_obs01", 2'd0, 1'b1, 5'b00100, 1'b0, 8'd0);
    // Zero seed reopens the set without counting
    seed("t4_seed0", 5'b00000, 5'b11111, 8'd0);
    obs("t4_obs21", 2'd2, 1'b1, 5'b00001, 1'b0, 8'd0);
    idle("t4_idle", 5'b00001, 8'd0);

    // Saturation of mismatch counter
    for (int i = 0; i < 300; i++) begin
      seed("t5_seed", 5'b00100, 5'b00100, 8'((i < 255) ? i : 255));
      obs("t5_mm", 2'd2, 1'b1, 5'b11111, 1'b1, 8'((i + 1 < 255) ? i + 1 : 255));
    end
    idle("t5_idle", 5'b11111, 8'd255);

    // Reset outranks seed and observation
    step("t6_all", 1'b1, 1'b1, 5'b00010, 1'b1, 2'd2, 1'b1, 5'b11111, 1'b0, 8'd0);
    idle("t6_idle", 5'b11111, 8'd0);

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries pending, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
